// File: rtl/psum_acc_seq_pkg.sv
// Shared package for psum_acc_seq: FSM states, psum width derivation,
// lane slicing helper and lane saturation limits.
package psum_pkg;

  localparam int unsigned COL   = 8;
  localparam int unsigned BW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  function automatic int unsigned psum_width(input int unsigned b);
    return 2 * b + 4;
  endfunction

  localparam int unsigned BW_PSUM = psum_width(BW);

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

  localparam logic [BW_PSUM-1:0] SAT_POS = {1'b0, {(BW_PSUM-1){1'b1}}};
  localparam logic [BW_PSUM-1:0] SAT_NEG = {1'b1, {(BW_PSUM-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_ACC_OUT,
    S_WAIT_PEER,
    S_DIV_OUT,
    S_FIN
  } state_t;

endpackage

// File: rtl/psum_acc_seq_lane_add.sv
// Single signed psum lane adder. With PSUM_SAT_EN defined it saturates to the
// lane limits and reports a clip; otherwise it wraps two's complement.
module psum_lane_add
  import psum_pkg::*;
#(
  parameter int unsigned w = BW_PSUM
) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic [w-1:0] sum
`ifdef PSUM_SAT_EN
  ,
  output logic         clip
`endif
);

`ifdef PSUM_SAT_EN
  localparam logic [w-1:0] POS = {1'b0, {(w-1){1'b1}}};
  localparam logic [w-1:0] NEG = {1'b1, {(w-1){1'b0}}};

  logic [w:0] ext;

  always_comb begin
    ext  = {a[w-1], a} + {b[w-1], b};
    clip = ext[w] ^ ext[w-1];
    if (!clip)
      sum = ext[w-1:0];
    else if (ext[w])
      sum = NEG;
    else
      sum = POS;
  end
`else
  always_comb sum = a + b;
`endif

endmodule

// File: rtl/psum_acc_seq.sv
// Multi-pass psum accumulator feeding the normalisation stage (acc phase,
// peer sum exchange, div phase). Optional lane saturation: PSUM_SAT_EN.
module psum_acc_seq
  import psum_pkg::*;
#(
  parameter int unsigned col     = COL,
  parameter int unsigned bw      = BW,
  parameter int unsigned bw_psum = psum_width(bw),
  parameter int unsigned depth   = DEPTH,
  parameter int unsigned aw      = AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [aw-1:0]          cfg_rows,
  input  logic [aw-1:0]          cfg_passes,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [col*bw_psum-1:0] in_data,
  input  logic                   peer_sum_ready,
  output logic                   my_sum_ready,
  output logic [col*bw_psum-1:0] sfp_data,
  output logic                   acc,
  output logic                   div,
  output logic                   fifo_ext_rd,
  output logic                   busy,
  output logic                   done
`ifdef PSUM_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int unsigned VW = col * bw_psum;

  state_t        state_q, state_d;
  logic [aw-1:0] r_q, r_d, p_q, p_d;
  logic [aw-1:0] rows_q, passes_q;
  logic          beat, start_ok;
  logic [VW-1:0] bank [depth];
  logic [VW-1:0] rd_vec, sum_vec, wr_vec, out_vec;
`ifdef PSUM_SAT_EN
  logic [col-1:0] clip_vec;
`endif

  assign in_ready = (state_q == S_ACCUM);
  assign beat     = in_valid & in_ready;
  assign start_ok = start & (state_q == S_IDLE);
  assign rd_vec   = bank[r_q];

  for (genvar i = 0; i < col; i++) begin : g_lane
    psum_lane_add #(.w(bw_psum)) u_add (
      .a   (rd_vec[lane_lo(i, bw_psum) +: bw_psum]),
      .b   (in_data[lane_lo(i, bw_psum) +: bw_psum]),
      .sum (sum_vec[lane_lo(i, bw_psum) +: bw_psum])
`ifdef PSUM_SAT_EN
      ,
      .clip(clip_vec[i])
`endif
    );
  end

  assign wr_vec = (p_q == '0) ? in_data : sum_vec;

  // Single-row jobs read the row being written on the same edge; forward it.
  assign out_vec = (beat && (r_q == r_d)) ? wr_vec : bank[r_d];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          r_d     = '0;
          p_d     = '0;
        end
      end
      S_ACCUM: begin
        if (beat) begin
          if (r_q == rows_q) begin
            r_d = '0;
            if (p_q == passes_q)
              state_d = S_ACC_OUT;
            else
              p_d = p_q + aw'(1);
          end else begin
            r_d = r_q + aw'(1);
          end
        end
      end
      S_ACC_OUT: begin
        if (r_q == rows_q) begin
          r_d     = '0;
          state_d = S_WAIT_PEER;
        end else begin
          r_d = r_q + aw'(1);
        end
      end
      S_WAIT_PEER: begin
        if (my_sum_ready && peer_sum_ready)
          state_d = S_DIV_OUT;
      end
      S_DIV_OUT: begin
        if (r_q == rows_q) begin
          r_d     = '0;
          state_d = S_FIN;
        end else begin
          r_d = r_q + aw'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the
  // state they describe and with the registered sfp_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      r_q          <= '0;
      p_q          <= '0;
      rows_q       <= '0;
      passes_q     <= '0;
      sfp_data     <= '0;
      acc          <= 1'b0;
      div          <= 1'b0;
      fifo_ext_rd  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      my_sum_ready <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      p_q          <= p_d;
      if (start_ok) begin
        rows_q   <= cfg_rows;
        passes_q <= cfg_passes;
      end
      if (state_d == S_ACC_OUT || state_d == S_DIV_OUT)
        sfp_data <= out_vec;
      acc          <= (state_d == S_ACC_OUT);
      div          <= (state_d == S_DIV_OUT);
      fifo_ext_rd  <= (state_d == S_DIV_OUT);
      busy         <= (state_d != S_IDLE);
      done         <= (state_d == S_FIN);
      my_sum_ready <= (state_q == S_WAIT_PEER) && (state_d == S_WAIT_PEER);
    end
  end

  always_ff @(posedge clk) begin
    if (beat)
      bank[r_q] <= wr_vec;
  end

`ifdef PSUM_SAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sat_flag <= 1'b0;
    else if (start_ok)
      sat_flag <= 1'b0;
    else if (beat && (p_q != '0) && (|clip_vec))
      sat_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_psum_acc_seq.sv
// Self-checking bench for psum_acc_seq against a lane-arithmetic reference
// model; build with PSUM_SAT_EN to exercise the saturating variant.
`timescale 1ns/1ps
module tb_psum_acc_seq;

  localparam int unsigned COLN = 8;
  localparam int unsigned PW   = 20;
  localparam int unsigned VW   = COLN * PW;
  localparam int          HALF = 524288;

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic          peer_sum_ready = 1'b0;
  logic [3:0]    cfg_rows = '0, cfg_passes = '0;
  logic [VW-1:0] in_data = '0;
  logic          in_ready, my_sum_ready, acc, div, fifo_ext_rd, busy, done;
  logic [VW-1:0] sfp_data;
`ifdef PSUM_SAT_EN
  logic          sat_flag;
`endif

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  psum_acc_seq #(.col(8), .bw(8), .depth(16), .aw(4)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_rows(cfg_rows),
    .cfg_passes(cfg_passes), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .peer_sum_ready(peer_sum_ready),
    .my_sum_ready(my_sum_ready), .sfp_data(sfp_data), .acc(acc), .div(div),
    .fifo_ext_rd(fifo_ext_rd), .busy(busy), .done(done)
`ifdef PSUM_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  // ---------------- reference model ----------------
  int stim [16][16][COLN];   // [pass][row][lane]

  function automatic int wrap_lane(input longint v);
    logic [PW-1:0] t;
    t = v[PW-1:0];
    return int'($signed(t));
  endfunction

  function automatic int model_lane(input int r, input int i, input int passes);
    longint a;
    a = stim[0][r][i];
    for (int p = 1; p <= passes; p++) begin
      a = a + stim[p][r][i];
`ifdef PSUM_SAT_EN
      if (a > HALF - 1) a = HALF - 1;
      else if (a < -HALF) a = -HALF;
`else
      a = wrap_lane(a);
`endif
    end
    return int'(a);
  endfunction

  function automatic logic [VW-1:0] exp_row(input int r, input int passes);
    logic [VW-1:0] v;
    logic [31:0]   t;
    for (int i = 0; i < COLN; i++) begin
      t = model_lane(r, i, passes);
      v[i*PW +: PW] = t[PW-1:0];
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] beat_vec(input int p, input int r);
    logic [VW-1:0] v;
    logic [31:0]   t;
    for (int i = 0; i < COLN; i++) begin
      t = stim[p][r][i];
      v[i*PW +: PW] = t[PW-1:0];
    end
    return v;
  endfunction

  // kind 0: lane i = 10*(i+1); 1: r+i-2; 2: full-range random
  task automatic fill(input int kind);
    for (int p = 0; p < 16; p++)
      for (int r = 0; r < 16; r++)
        for (int i = 0; i < COLN; i++)
          case (kind)
            0:       stim[p][r][i] = 10 * (i + 1);
            1:       stim[p][r][i] = r + i - 2;
            default: stim[p][r][i] = int'($urandom_range(0, 1048575)) - HALF;
          endcase
  endtask

  // ---------------- output monitor ----------------
  logic [VW-1:0] acc_rows[$], div_rows[$];
  int acc_cyc[$], div_cyc[$];
  int cyc = 0, strobe_err = 0, done_cnt = 0, done_cyc = -1;
  logic msr_at_div = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (acc === 1'b1) begin acc_rows.push_back(sfp_data); acc_cyc.push_back(cyc); end
    if (div === 1'b1) begin
      if (div_rows.size() == 0) msr_at_div = my_sum_ready;
      div_rows.push_back(sfp_data); div_cyc.push_back(cyc);
    end
    if (((acc & div) | (div ^ fifo_ext_rd)) !== 1'b0) strobe_err++;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic clear_mon();
    acc_rows.delete(); div_rows.delete(); acc_cyc.delete(); div_cyc.delete();
    strobe_err = 0; done_cnt = 0; done_cyc = -1; msr_at_div = 1'b0;
  endtask

  // ---------------- job drivers ----------------
  int last_beat_cyc, msr_first_cyc, peer_cyc, timed_out;
  logic busy_at_start, busy_after_done;

  task automatic start_job(input int rows, input int passes);
    clear_mon();
    timed_out = 0;
    cfg_rows = 4'(rows); cfg_passes = 4'(passes); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_at_start = busy;
    cfg_rows = 4'($urandom); cfg_passes = 4'($urandom);
  endtask

  task automatic send_beats(input int rows, input int passes, input bit toggle, input bit mid_start);
    int guard, n;
    bit v, took;
    v = 1'b0; n = 0;
    for (int p = 0; p <= passes; p++)
      for (int r = 0; r <= rows; r++) begin
        in_data = beat_vec(p, r);
        guard = 0;
        do begin
          v = toggle ? !v : 1'b1;
          in_valid = v;
          start = mid_start && (n == 3);
          took = v && (in_ready === 1'b1);
          @(posedge clk); #1;
          guard++;
        end while (!took && guard < 50);
        if (!took) timed_out = 1;
        n++;
      end
    in_valid = 1'b0; start = 1'b0;
    last_beat_cyc = cyc;
  endtask

  task automatic finish_job(input int peer_delay);
    int guard, seen;
    guard = 0; seen = 0; msr_first_cyc = -1; peer_cyc = -1;
    while (done !== 1'b1 && guard < 400) begin
      if (my_sum_ready === 1'b1) begin
        if (msr_first_cyc < 0) msr_first_cyc = cyc;
        seen++;
      end
      if (peer_cyc < 0 && my_sum_ready === 1'b1 && seen > peer_delay) begin
        peer_sum_ready = 1'b1; peer_cyc = cyc;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (done !== 1'b1) timed_out = 1;
    peer_sum_ready = 1'b0;
    @(posedge clk); #1;
    busy_after_done = busy;
  endtask

  task automatic run_job(input int rows, input int passes, input bit toggle,
                         input bit mid_start, input int peer_delay);
    start_job(rows, passes);
    send_beats(rows, passes, toggle, mid_start);
    finish_job(peer_delay);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({acc, div, fifo_ext_rd, busy, done, in_ready, my_sum_ready} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got=%b want=0000000", {acc, div, fifo_ext_rd, busy, done, in_ready, my_sum_ready}); end
    checks++; if (sfp_data !== '0) begin errors++; $display("FAIL reset_sfp got=%h want=0", sfp_data); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, in_ready} !== 2'b00) begin errors++; $display("FAIL idle_after_reset got=%b want=00", {busy, in_ready}); end
  endtask

  task automatic test_single_row();
    fill(0);
    run_job(0, 0, 1'b0, 1'b0, 0);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL single_timeout got=%0d want=0", timed_out); end
    checks++; if (busy_at_start !== 1'b1) begin errors++; $display("FAIL single_busy got=%b want=1", busy_at_start); end
    checks++; if (acc_rows.size() != 1 || acc_rows[0] !== beat_vec(0, 0)) begin
      errors++; $display("FAIL single_acc n=%0d got=%h want=%h", acc_rows.size(), acc_rows.size() ? acc_rows[0] : '0, beat_vec(0, 0)); end
    checks++; if (acc_cyc.size() != 1 || acc_cyc[0] != last_beat_cyc) begin
      errors++; $display("FAIL single_acc_latency got=%0d want=%0d", acc_cyc.size() ? acc_cyc[0] : -1, last_beat_cyc); end
    checks++; if (div_rows.size() != 1 || div_rows[0] !== exp_row(0, 0)) begin
      errors++; $display("FAIL single_div n=%0d want=1 row %h", div_rows.size(), exp_row(0, 0)); end
    checks++; if (msr_first_cyc != last_beat_cyc + 2) begin
      errors++; $display("FAIL single_msr_time got=%0d want=%0d", msr_first_cyc, last_beat_cyc + 2); end
    checks++; if (done_cnt != 1 || div_cyc.size() != 1 || done_cyc != div_cyc[0] + 1) begin
      errors++; $display("FAIL single_done cnt=%0d at=%0d want 1 at div+1", done_cnt, done_cyc); end
    checks++; if (busy_after_done !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b want=0", busy_after_done); end
    checks++; if (strobe_err != 0) begin errors++; $display("FAIL single_strobes got=%0d want=0", strobe_err); end
  endtask

  task automatic test_multi_pass();
    logic [VW-1:0] row0;
    fill(1);
    run_job(3, 2, 1'b0, 1'b0, 0);
    checks++; if (timed_out != 0 || acc_rows.size() != 4) begin
      errors++; $display("FAIL multi_acc_count got=%0d want=4 timeout=%0d", acc_rows.size(), timed_out); end
    for (int r = 0; r < acc_rows.size(); r++) begin
      checks++; if (acc_rows[r] !== exp_row(r, 2) || acc_cyc[r] != last_beat_cyc + r) begin
        errors++; $display("FAIL multi_acc_row%0d got=%h @%0d want=%h @%0d", r, acc_rows[r], acc_cyc[r], exp_row(r, 2), last_beat_cyc + r); end
    end
    row0 = acc_rows.size() ? acc_rows[0] : '0;
    checks++; if ($signed(row0[PW-1:0]) != -6) begin
      errors++; $display("FAIL multi_row0_lane0 got=%0d want=-6", $signed(row0[PW-1:0])); end
    checks++; if (div_rows.size() != 4) begin errors++; $display("FAIL multi_div_count got=%0d want=4", div_rows.size()); end
    for (int r = 0; r < div_rows.size(); r++) begin
      checks++; if (div_rows[r] !== exp_row(r, 2) || div_cyc[r] != div_cyc[0] + r) begin
        errors++; $display("FAIL multi_div_row%0d got=%h want=%h", r, div_rows[r], exp_row(r, 2)); end
    end
    checks++; if (done_cnt != 1 || strobe_err != 0) begin
      errors++; $display("FAIL multi_done_strobes done=%0d strobe_err=%0d want 1/0", done_cnt, strobe_err); end
  endtask

  task automatic test_peer_wait();
    int rows, passes;
    fill(2);
    rows = 3; passes = int'($urandom_range(0, 4));
    run_job(rows, passes, 1'b0, 1'b0, 10);
    checks++; if (msr_first_cyc != last_beat_cyc + rows + 2) begin
      errors++; $display("FAIL peer_msr_time got=%0d want=%0d", msr_first_cyc, last_beat_cyc + rows + 2); end
    checks++; if (peer_cyc != msr_first_cyc + 10) begin
      errors++; $display("FAIL peer_hold got=%0d want=%0d", peer_cyc, msr_first_cyc + 10); end
    checks++; if (div_cyc.size() != 4 || div_cyc[0] != peer_cyc + 1) begin
      errors++; $display("FAIL peer_div_start n=%0d at=%0d want 4 at %0d", div_cyc.size(), div_cyc.size() ? div_cyc[0] : -1, peer_cyc + 1); end
    checks++; if (msr_at_div !== 1'b0) begin errors++; $display("FAIL peer_msr_drop got=%b want=0", msr_at_div); end
    for (int r = 0; r < div_rows.size(); r++) begin
      checks++; if (div_rows[r] !== exp_row(r, passes)) begin
        errors++; $display("FAIL peer_div_row%0d got=%h want=%h", r, div_rows[r], exp_row(r, passes)); end
    end
    checks++; if (done_cyc - last_beat_cyc != 2 * (rows + 1) + (div_cyc.size() ? div_cyc[0] - acc_cyc[rows] - 1 : 0)) begin
      errors++; $display("FAIL peer_total_latency got=%0d", done_cyc - last_beat_cyc); end
  endtask

  task automatic test_valid_toggle();
    fill(1);
    run_job(3, 2, 1'b1, 1'b1, 0);
    checks++; if (timed_out != 0 || acc_rows.size() != 4 || div_rows.size() != 4 || done_cnt != 1) begin
      errors++; $display("FAIL toggle_counts acc=%0d div=%0d done=%0d want 4/4/1", acc_rows.size(), div_rows.size(), done_cnt); end
    for (int r = 0; r < acc_rows.size(); r++) begin
      checks++; if (acc_rows[r] !== exp_row(r, 2)) begin
        errors++; $display("FAIL toggle_acc_row%0d got=%h want=%h", r, acc_rows[r], exp_row(r, 2)); end
    end
  endtask

  task automatic test_reset_mid_job();
    int guard;
    fill(2);
    start_job(3, 0);
    send_beats(3, 0, 1'b0, 1'b0);
    guard = 0;
    while (cyc < last_beat_cyc + 2 && guard < 20) begin @(posedge clk); #1; guard++; end
    #1;
    checks++; if (acc !== 1'b1 || sfp_data !== exp_row(2, 0)) begin
      errors++; $display("FAIL midrst_row2 acc=%b got=%h want=%h", acc, sfp_data, exp_row(2, 0)); end
    reset = 1'b0;
    #1;
    checks++; if ({acc, div, fifo_ext_rd, busy, done, in_ready, my_sum_ready} !== 7'b0 || sfp_data !== '0) begin
      errors++; $display("FAIL midrst_outputs got=%b sfp=%h want all 0", {acc, div, fifo_ext_rd, busy, done, in_ready, my_sum_ready}, sfp_data); end
    repeat (4) @(posedge clk);
    #1; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midrst_no_done got=%0d want=0", done_cnt); end
    fill(2);
    run_job(1, 1, 1'b0, 1'b0, 2);
    checks++; if (timed_out != 0 || acc_rows.size() != 2 || div_rows.size() != 2 || done_cnt != 1) begin
      errors++; $display("FAIL midrst_rerun acc=%0d div=%0d done=%0d want 2/2/1", acc_rows.size(), div_rows.size(), done_cnt); end
    for (int r = 0; r < acc_rows.size(); r++) begin
      checks++; if (acc_rows[r] !== exp_row(r, 1)) begin
        errors++; $display("FAIL midrst_rerun_row%0d got=%h want=%h", r, acc_rows[r], exp_row(r, 1)); end
    end
  endtask

  task automatic test_random_jobs();
    int rows, passes;
    for (int j = 0; j < 4; j++) begin
      fill(2);
      rows = int'($urandom_range(0, 15)); passes = int'($urandom_range(0, 5));
      run_job(rows, passes, j[0], 1'b0, int'($urandom_range(0, 3)));
      checks++; if (timed_out != 0 || acc_rows.size() != rows + 1 || div_rows.size() != rows + 1 || done_cnt != 1 || strobe_err != 0) begin
        errors++; $display("FAIL rand%0d_counts acc=%0d div=%0d done=%0d serr=%0d want %0d/%0d/1/0", j, acc_rows.size(), div_rows.size(), done_cnt, strobe_err, rows + 1, rows + 1); end
      for (int r = 0; r < acc_rows.size(); r++) begin
        checks++; if (acc_rows[r] !== exp_row(r, passes) || (r < div_rows.size() && div_rows[r] !== exp_row(r, passes))) begin
          errors++; $display("FAIL rand%0d_row%0d acc=%h want=%h", j, r, acc_rows[r], exp_row(r, passes)); end
      end
    end
  endtask

  task automatic test_saturation();
    logic [VW-1:0] row;
    int want;
    fill(2);
    stim[0][0][0] = HALF - 1;
    stim[1][0][0] = HALF - 1;
`ifdef PSUM_SAT_EN
    want = 524287;
`else
    want = -2;
`endif
    run_job(0, 1, 1'b0, 1'b0, 0);
    row = acc_rows.size() ? acc_rows[0] : '0;
    checks++; if ($signed(row[PW-1:0]) != want) begin
      errors++; $display("FAIL sat_lane0 got=%0d want=%0d", $signed(row[PW-1:0]), want); end
    checks++; if (row !== exp_row(0, 1)) begin errors++; $display("FAIL sat_row got=%h want=%h", row, exp_row(0, 1)); end
`ifdef PSUM_SAT_EN
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set got=%b want=1", sat_flag); end
    fill(1);
    run_job(1, 1, 1'b0, 1'b0, 0);
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_clear got=%b want=0", sat_flag); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_multi_pass();
    test_peer_wait();
    test_valid_toggle();
    test_reset_mid_job();
    test_random_jobs();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/psum_acc_seq.md
Name: psum_acc_seq

Overview:
- Upstream neighbour of the softmax/normalisation row stage.
- Accumulates per-row column psums from the MAC array across multiple K passes into a local bank.
- Replays the bank to the normalisation stage in two phases: an acc phase that builds the row sums, then a div phase that divides.
- Handles the two-core sum-exchange handshake between the phases.

Parameters:
- col, 8, number of psum lanes per row
- bw, 8, activation/weight bit width
- bw_psum, 2*bw+4, signed psum lane width
- depth, 16, maximum rows held in the bank
- aw, 4, log2(depth); width of row and pass counters

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, asynchronous and active-low
- start  in  1  one-cycle pulse; begins a job when idle
- cfg_rows  in  aw  number of rows minus 1
- cfg_passes  in  aw  number of K passes minus 1
- in_valid  in  1  psum vector valid
- in_ready  out  1  block accepts a psum vector
- in_data  in  col*bw_psum  signed psum vector; lane i at [bw_psum*(i+1)-1 : bw_psum*i]
- peer_sum_ready  in  1  peer core has its row sums written
- my_sum_ready  out  1  this core has its row sums written
- sfp_data  out  col*bw_psum  row vector to the normalisation stage
- acc  out  1  normalisation-stage accumulate strobe
- div  out  1  normalisation-stage divide strobe
- fifo_ext_rd  out  1  pops the exported-sum FIFO
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: state IDLE, counters 0, all outputs 0. Bank contents are not reset.
- Reset asserted mid-job aborts immediately to IDLE with no done pulse.
- cfg_rows and cfg_passes are latched on an accepted start; later changes have no effect on the running job.
- States and transitions: IDLE -> ACCUM -> ACC_OUT -> WAIT_PEER -> DIV_OUT -> FIN -> IDLE.
- IDLE:
  - start=1 latches config, clears row counter r and pass counter p, sets busy, goes to ACCUM.
  - start while busy is ignored.
- ACCUM:
  - in_ready=1.
  - A beat is in_valid & in_ready.
  - Beats arrive row-major within a pass: r = 0..cfg_rows, then p increments.
  - Pass 0 writes bank[r] = in_data. Passes >0 do a lane-wise signed add, bank[r] += in_data, at bw_psum width; wrap is two's complement unless SAT_EN.
  - When the beat with r=cfg_rows and p=cfg_passes is accepted, in_ready drops the next cycle and the state goes to ACC_OUT with r=0.
  - in_valid=0 cycles stall with no state change.
  - in_valid outside ACCUM is ignored (in_ready=0).
- ACC_OUT:
  - One row per cycle: registered sfp_data=bank[r], acc=1, for cfg_rows+1 consecutive cycles.
  - Then go to WAIT_PEER.
- WAIT_PEER:
  - acc=0.
  - my_sum_ready asserts from the 2nd cycle in this state onward, covering the downstream one-cycle sum register plus FIFO write.
  - Leave when my_sum_ready & peer_sum_ready; minimum 2 cycles in this state.
  - my_sum_ready stays high until the DIV_OUT entry cycle and deasserts on it.
- DIV_OUT:
  - One row per cycle: sfp_data=bank[r], div=1, fifo_ext_rd=1, for cfg_rows+1 cycles, no stalls.
  - Then go to FIN.
- FIN: done=1 for one cycle, busy=0 on the next cycle, state IDLE.
- Strobe alignment: acc, div, fifo_ext_rd and sfp_data are registered and change on the same edge; never acc and div in the same cycle.
- Latency:
  - First acc occurs 1 cycle after the last accumulate beat.
  - Total after the last beat is (cfg_rows+1) + wait + (cfg_rows+1) + 1 cycles.
- Boundary values:
  - cfg_rows=0 gives single-row phases.
  - cfg_passes=0 gives pure load, no add.
  - r and p wrap only via their terminal compare; values beyond depth-1 cannot occur because aw bounds them.

Optional Feature:
- Macro: PSUM_SAT_EN.
- Defined: pass-accumulate adds saturate per lane to +(2^(bw_psum-1)-1) / -(2^(bw_psum-1)), and a sticky output sat_flag (1 bit) sets on any clip. sat_flag clears on accepted start or reset.
- Undefined: adds wrap modulo 2^bw_psum and the sat_flag port is absent.

Decomposition:
- Shared package psum_pkg:
  - state encoding (IDLE, ACCUM, ACC_OUT, WAIT_PEER, DIV_OUT, FIN)
  - bw_psum derivation
  - lane slice helper constants
  - saturation limit constants
- One sub-module, psum_lane_add: a single bw_psum signed adder with optional saturation and a clip output. It is instantiated col times.

Test Plan:
1. cfg_rows=0, cfg_passes=0, lane i=10*(i+1) -> one acc cycle with sfp_data equal to the input; after peer_sum_ready, one div+fifo_ext_rd cycle; done pulse; busy then 0.
2. cfg_rows=3, cfg_passes=2, each pass row r lane i = r+i-2 -> bank = 3*(r+i-2), e.g. row0 lane0 = -6; acc cycles emit rows 0..3 in order on 4 consecutive cycles.
3. peer_sum_ready held 0 for 10 cycles -> my_sum_ready=1 from the 2nd WAIT_PEER cycle, no div; raise peer -> div on the next cycle for 4 rows.
4. in_valid toggled 1/0 every cycle, plus start pulsed mid-ACCUM -> beats accepted only when valid, start ignored, and results match scenario 2.
5. Reset low during ACC_OUT row 2 -> all outputs 0 immediately, no done; a new start with cfg_rows=1 completes correctly.
6. PSUM_SAT_EN build: two passes of lane0 = 2^(bw_psum-1)-1 -> lane0 saturates to 524287 (bw_psum=20) and sat_flag=1. Without the macro -> lane0 = -2 (wrapped).
